axis_master: RTL and testbench
==============================

Name: axis_master

Overview:
- Transmit-side counterpart of the AXI-Stream receive path: accepts beats from a backend valid/ready source and drives them onto an AXI-Stream master port.
- A DEPTH-entry FIFO decouples backend timing from downstream tready stalls, so the backend sees no combinational path from axis_tready.
- Tracks packet boundaries (tlast) and reports completed-packet count and FIFO occupancy for status/debug.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >= 2.
- CW, $clog2(DEPTH)+1, occupancy counter width (derived, not overridden).

Ports:
- axi_aclk  input  1  clock
- axi_aresetn  input  1  asynchronous active-low reset
- bk_data  input  32  backend beat data
- bk_tstrb  input  4  backend byte strobes
- bk_tkeep  input  4  backend byte keeps
- bk_user  input  2  backend sideband (maps to tuser)
- bk_tlast  input  1  backend end-of-packet
- bk_valid  input  1  backend beat valid
- bk_ready  output  1  block can accept a beat (registered)
- axis_tvalid  output  1  AXIS master valid
- axis_tdata  output  32  AXIS data
- axis_tstrb  output  4  AXIS strobes
- axis_tkeep  output  4  AXIS keeps
- axis_tlast  output  1  AXIS last
- axis_tuser  output  2  AXIS user
- axis_tready  input  1  AXIS slave ready
- fifo_count  output  CW  entries currently held, 0..DEPTH
- in_packet  output  1  a packet has started on AXIS but its tlast beat is not yet sent
- pkt_done  output  1  one-cycle pulse after a tlast beat is sent
- pkt_cnt  output  16  completed packets sent, wraps 0xFFFF->0

Behaviour:
- Reset (axi_aresetn low, asynchronous): FIFO flushed (rd/wr pointers 0, count 0), bk_ready=0, axis_tvalid=0, all axis_* payload=0, in_packet=0, pkt_done=0, pkt_cnt=0, fifo_count=0.
- bk_ready rises on the first axi_aclk edge after reset release.
- push = bk_valid & bk_ready; pop = axis_tvalid & axis_tready.
- bk_ready is a flop: next value = (count_next < DEPTH). It never depends combinationally on axis_tready.
- The block never pushes when full; bk_valid with bk_ready=0 is ignored and the backend must hold its beat.
- Storage: pushed beat = {data, tstrb, tkeep, user, tlast} is written at wr_ptr; pointers wrap modulo DEPTH.
- axis_tvalid = (count != 0). When axis_tvalid=1, payload = head entry; when 0, all payload outputs = 0.
- Latency: beat pushed at edge N is visible on AXIS after edge N when the FIFO was empty (1 cycle). No same-cycle bypass.
- AXIS rule: once axis_tvalid=1, payload and tvalid stay stable until pop. A push never alters the head entry.
- Simultaneous push and pop: count unchanged, both pointers advance; legal at any non-empty, non-full count.
- Full with pop: count -> DEPTH-1, bk_ready=1 next cycle. The push slot opens one cycle after a pop, never in the same cycle.
- fifo_count is registered and equals count.
- Output-side FSM, states AXIS_IDLE / AXIS_IN_PKT:
  - AXIS_IDLE -> AXIS_IN_PKT on pop with tlast=0.
  - AXIS_IDLE stays AXIS_IDLE on pop with tlast=1 (single-beat packet).
  - AXIS_IN_PKT -> AXIS_IDLE on pop with tlast=1.
  - All other cases hold state.
  - in_packet = (state == AXIS_IN_PKT).
- pkt_done: registered; 1 for exactly one cycle after any pop with tlast=1, otherwise 0.
- pkt_cnt increments on that same pop, 16-bit wrap.
- Reset mid-packet: all buffered beats are discarded and the FSM returns to AXIS_IDLE. No partial-packet recovery.

Test Plan:
- Reset, then one beat {data=0xA5A5_0001, tstrb=0xF, tkeep=0xF, user=2'b01, tlast=1} with axis_tready=1 -> bk_ready=1 from 1st edge after reset; axis_tvalid high exactly one cycle after push with matching payload; pkt_done pulses the next cycle; pkt_cnt=1.
- Hold axis_tready=0 and push 0x1..0x5 back-to-back (DEPTH=4) -> 4 accepted; bk_ready=0 once fifo_count=4; beat 0x5 held by the backend; axis payload stays 0x1 throughout.
- From the full state, raise axis_tready -> 0x1,0x2,0x3,0x4,0x5 emitted in order with no duplicates or loss; bk_ready reasserts the cycle after the first pop.
- Continuous push with axis_tready=1, 8-beat packet, tlast on beat 8 -> fifo_count stays at 1 in steady state; in_packet=1 from beat 1 pop until beat 8 pop; pkt_done pulses once; pkt_cnt +1.
- Randomised axis_tready (50%) over 1000 beats with pointer wrap -> output sequence equals input sequence; payload never changes while tvalid=1 and tready=0.
- Assert reset with 3 beats buffered mid-packet -> axis_tvalid=0, fifo_count=0, in_packet=0, pkt_cnt=0 immediately; a fresh 2-beat packet after release transmits correctly.

Source files
------------

// File: rtl/axis_master.sv
// axis_master: buffers backend beats in a DEPTH-entry FIFO and drives them onto an AXI-Stream master port,
// tracking packet boundaries and reporting packet count and occupancy.
module axis_master #(
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic          axi_aclk,
    input  logic          axi_aresetn,
    input  logic [31:0]   bk_data,
    input  logic [3:0]    bk_tstrb,
    input  logic [3:0]    bk_tkeep,
    input  logic [1:0]    bk_user,
    input  logic          bk_tlast,
    input  logic          bk_valid,
    output logic          bk_ready,
    output logic          axis_tvalid,
    output logic [31:0]   axis_tdata,
    output logic [3:0]    axis_tstrb,
    output logic [3:0]    axis_tkeep,
    output logic          axis_tlast,
    output logic [1:0]    axis_tuser,
    input  logic          axis_tready,
    output logic [CW-1:0] fifo_count,
    output logic          in_packet,
    output logic          pkt_done,
    output logic [15:0]   pkt_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int BW = 43;
    localparam logic [0:0] AXIS_IDLE   = 1'b0;
    localparam logic [0:0] AXIS_IN_PKT = 1'b1;

    logic [BW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr, r_rd;
    logic [CW-1:0] r_count;
    logic          r_bk_ready, r_pkt_done;
    logic [0:0]    r_state;
    logic [15:0]   r_pkt_cnt;
    logic          w_push, w_pop, w_valid, w_last_pop;
    logic [CW-1:0] w_count_next;
    logic [BW-1:0] w_head;

    assign w_valid      = r_count != '0;
    assign w_push       = bk_valid & r_bk_ready;
    assign w_pop        = w_valid & axis_tready;
    assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);
    // Payload is forced to zero whenever nothing is buffered.
    assign w_head       = w_valid ? r_mem[r_rd] : '0;
    assign w_last_pop   = w_pop & w_head[0];

    assign {axis_tdata, axis_tstrb, axis_tkeep, axis_tuser, axis_tlast} = w_head;
    assign axis_tvalid = w_valid;
    assign bk_ready    = r_bk_ready;
    assign fifo_count  = r_count;
    assign in_packet   = r_state == AXIS_IN_PKT;
    assign pkt_done    = r_pkt_done;
    assign pkt_cnt     = r_pkt_cnt;

    always_ff @(posedge axi_aclk) begin
        if (w_push) r_mem[r_wr] <= {bk_data, bk_tstrb, bk_tkeep, bk_user, bk_tlast};
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            r_wr       <= '0;
            r_rd       <= '0;
            r_count    <= '0;
            r_bk_ready <= 1'b0;
            r_pkt_done <= 1'b0;
            r_pkt_cnt  <= '0;
            r_state    <= AXIS_IDLE;
        end else begin
            if (w_push) r_wr <= r_wr + AW'(1);
            if (w_pop) r_rd <= r_rd + AW'(1);
            r_count <= w_count_next;
            // Ready is a flop of next occupancy, so it never follows axis_tready combinationally.
            r_bk_ready <= w_count_next < CW'(DEPTH);
            r_pkt_done <= w_last_pop;
            if (w_last_pop) r_pkt_cnt <= r_pkt_cnt + 16'd1;
            if (w_pop) r_state <= w_head[0] ? AXIS_IDLE : AXIS_IN_PKT;
        end
    end
endmodule

// File: tb/tb_axis_master.sv
// tb_axis_master: directed checks of the AXI-Stream master FIFO, packet tracking and reset behaviour.
`define CHK(t, o, e) chk(t, 64'(o), 64'(e))
module tb_axis_master;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] bk_data;
  logic [3:0]  bk_tstrb, bk_tkeep;
  logic [1:0]  bk_user;
  logic        bk_tlast, bk_valid, bk_ready;
  logic        axis_tvalid, axis_tlast, axis_tready;
  logic [31:0] axis_tdata;
  logic [3:0]  axis_tstrb, axis_tkeep;
  logic [1:0]  axis_tuser;
  logic [2:0]  fifo_count;
  logic        in_packet, pkt_done;
  logic [15:0] pkt_cnt;
  int checks = 0;
  int errors = 0;
  axis_master #(.DEPTH(4)) dut (
    .axi_aclk(clk), .axi_aresetn(rst_n),
    .bk_data(bk_data), .bk_tstrb(bk_tstrb), .bk_tkeep(bk_tkeep), .bk_user(bk_user),
    .bk_tlast(bk_tlast), .bk_valid(bk_valid), .bk_ready(bk_ready),
    .axis_tvalid(axis_tvalid), .axis_tdata(axis_tdata), .axis_tstrb(axis_tstrb),
    .axis_tkeep(axis_tkeep), .axis_tlast(axis_tlast), .axis_tuser(axis_tuser),
    .axis_tready(axis_tready), .fifo_count(fifo_count), .in_packet(in_packet),
    .pkt_done(pkt_done), .pkt_cnt(pkt_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [31:0] d, input logic last);
    bk_data  = d;
    bk_tstrb = 4'hF;
    bk_tkeep = 4'hF;
    bk_user  = d[1:0];
    bk_tlast = last;
    bk_valid = 1'b1;
  endtask
  initial begin
    int sent, rcvd, cyc;
    logic push, hold;
    logic [31:0] hold_d;
    rst_n = 1'b0;
    bk_data = '0; bk_tstrb = '0; bk_tkeep = '0; bk_user = '0; bk_tlast = 1'b0;
    bk_valid = 1'b0; axis_tready = 1'b0;
    #12;
    `CHK("rst_ready", bk_ready, 0);
    `CHK("rst_tvalid", axis_tvalid, 0);
    `CHK("rst_tdata", axis_tdata, 0);
    `CHK("rst_count", fifo_count, 0);
    `CHK("rst_pktcnt", pkt_cnt, 0);
    rst_n = 1'b1;
    #1;
    `CHK("ready_before_edge", bk_ready, 0);
    step();
    `CHK("ready_first_edge", bk_ready, 1);
    drive(32'hA5A5_0001, 1'b1);
    bk_user = 2'b01;
    axis_tready = 1'b1;
    step();
    bk_valid = 1'b0;
    `CHK("t1_tvalid", axis_tvalid, 1);
    `CHK("t1_tdata", axis_tdata, 32'hA5A5_0001);
    `CHK("t1_tstrb", axis_tstrb, 4'hF);
    `CHK("t1_tkeep", axis_tkeep, 4'hF);
    `CHK("t1_tuser", axis_tuser, 2'b01);
    `CHK("t1_tlast", axis_tlast, 1);
    `CHK("t1_done_early", pkt_done, 0);
    step();
    `CHK("t1_tvalid_after", axis_tvalid, 0);
    `CHK("t1_tdata_zero", axis_tdata, 0);
    `CHK("t1_done", pkt_done, 1);
    `CHK("t1_pktcnt", pkt_cnt, 1);
    `CHK("t1_inpkt", in_packet, 0);
    step();
    `CHK("t1_done_pulse", pkt_done, 0);
    axis_tready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      drive(32'(i), 1'b0);
      step();
      `CHK("t2_count", fifo_count, i);
      `CHK("t2_head", axis_tdata, 1);
    end
    `CHK("t2_full_ready", bk_ready, 0);
    drive(32'd5, 1'b1);
    step();
    step();
    `CHK("t2_hold_count", fifo_count, 4);
    `CHK("t2_hold_ready", bk_ready, 0);
    `CHK("t2_hold_head", axis_tdata, 1);
    `CHK("t2_hold_tvalid", axis_tvalid, 1);
    axis_tready = 1'b1;
    step();
    `CHK("t3_ready_back", bk_ready, 1);
    `CHK("t3_count_a", fifo_count, 3);
    `CHK("t3_d2", axis_tdata, 2);
    `CHK("t3_inpkt", in_packet, 1);
    step();
    bk_valid = 1'b0;
    `CHK("t3_count_b", fifo_count, 3);
    `CHK("t3_d3", axis_tdata, 3);
    step();
    `CHK("t3_d4", axis_tdata, 4);
    step();
    `CHK("t3_d5", axis_tdata, 5);
    `CHK("t3_last5", axis_tlast, 1);
    `CHK("t3_count_c", fifo_count, 1);
    step();
    `CHK("t3_empty", axis_tvalid, 0);
    `CHK("t3_done", pkt_done, 1);
    `CHK("t3_pktcnt", pkt_cnt, 2);
    `CHK("t3_inpkt_end", in_packet, 0);
    for (int i = 1; i <= 8; i++) begin
      drive(32'h100 + 32'(i), i == 8);
      step();
      `CHK("t4_count", fifo_count, 1);
      `CHK("t4_data", axis_tdata, 32'h100 + 32'(i));
      `CHK("t4_inpkt", in_packet, i >= 2);
      `CHK("t4_done_quiet", pkt_done, 0);
    end
    bk_valid = 1'b0;
    step();
    `CHK("t4_done", pkt_done, 1);
    `CHK("t4_pktcnt", pkt_cnt, 3);
    `CHK("t4_inpkt_end", in_packet, 0);
    step();
    `CHK("t4_done_once", pkt_done, 0);
    sent = 0; rcvd = 0; cyc = 0;
    while (rcvd < 1000 && cyc < 20000) begin
      axis_tready = 1'($urandom_range(0, 1));
      drive(32'(sent) ^ 32'h5A00_0000, (sent % 5) == 4);
      bk_valid = sent < 1000;
      push = bk_valid && bk_ready;
      hold = axis_tvalid && !axis_tready;
      hold_d = axis_tdata;
      if (axis_tvalid && axis_tready) begin
        checks += 2;
        if (axis_tdata !== (32'(rcvd) ^ 32'h5A00_0000)) begin
          errors++;
          $error("FAIL rnd_data: observed %0h expected %0h", axis_tdata, 32'(rcvd) ^ 32'h5A00_0000);
        end
        if (axis_tlast !== ((rcvd % 5) == 4)) begin
          errors++;
          $error("FAIL rnd_last: observed %0h at beat %0d", axis_tlast, rcvd);
        end
        rcvd++;
      end
      step();
      if (push) sent++;
      if (hold) begin
        checks++;
        if (axis_tdata !== hold_d) begin
          errors++;
          $error("FAIL rnd_stable: observed %0h expected %0h", axis_tdata, hold_d);
        end
      end
      cyc++;
    end
    bk_valid = 1'b0;
    `CHK("rnd_received", rcvd, 1000);
    `CHK("rnd_pktcnt", pkt_cnt, 203);
    `CHK("rnd_empty", fifo_count, 0);
    axis_tready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(32'hC0 + 32'(i), 1'b0);
      step();
    end
    bk_valid = 1'b0;
    axis_tready = 1'b1;
    step();
    axis_tready = 1'b0;
    `CHK("t6_pre_inpkt", in_packet, 1);
    `CHK("t6_pre_count", fifo_count, 3);
    #2;
    rst_n = 1'b0;
    #1;
    `CHK("t6_tvalid", axis_tvalid, 0);
    `CHK("t6_count", fifo_count, 0);
    `CHK("t6_inpkt", in_packet, 0);
    `CHK("t6_pktcnt", pkt_cnt, 0);
    `CHK("t6_ready", bk_ready, 0);
    rst_n = 1'b1;
    step();
    `CHK("t6_ready_back", bk_ready, 1);
    axis_tready = 1'b1;
    drive(32'hB1, 1'b0);
    step();
    `CHK("t6_b1", axis_tdata, 32'hB1);
    drive(32'hB2, 1'b1);
    step();
    bk_valid = 1'b0;
    `CHK("t6_b2", axis_tdata, 32'hB2);
    `CHK("t6_inpkt2", in_packet, 1);
    step();
    `CHK("t6_done", pkt_done, 1);
    `CHK("t6_pktcnt2", pkt_cnt, 1);
    `CHK("t6_idle", in_packet, 0);
    `CHK("t6_empty", axis_tvalid, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
